pong_game_ctrl: RTL

Game-level sequencer for the pong display. It sits beside the VGA sync circuit and the pong graphics generator and decides when the ball and paddle move or freeze. It counts remaining balls and the score, and runs a frame-based 2 s pause between rounds. It consumes per-frame hit/miss events from the graphics unit and player buttons, and drives the freeze control and status used by the text overlay.

---
 rtl/pong_ctrl_pkg.sv | 19 +
 rtl/pong_game_ctrl_if.sv | 32 +++
 rtl/pong_ctrl_timer.sv | 32 +++
 rtl/pong_game_ctrl.sv | 129 ++++++++++++
 4 files changed

// File: rtl/pong_ctrl_pkg.sv
// pong_ctrl_pkg: shared types and constants for the pong game controller.
//   state_t         game state encoding (also the value shown on the state port)
//   BALLS_DEF       default number of balls per game
//   TIMER_TICKS_DEF default pause length in refresh ticks (2 s at 60 Hz)
//   BCD_W           width of one BCD score digit
package pong_ctrl_pkg;

  typedef enum logic [1:0] {
    NEWGAME = 2'b00,
    PLAY    = 2'b01,
    NEWBALL = 2'b10,
    OVER    = 2'b11
  } state_t;

  localparam int BALLS_DEF       = 3;
  localparam int TIMER_TICKS_DEF = 120;
  localparam int BCD_W           = 4;

endpackage

// File: rtl/pong_game_ctrl_if.sv
// pong_game_ctrl_if: event/status bundle between the pong graphics side and
// the game controller.
//   refr_tick  frame pulse at start of vertical blank
//   btn        debounced player buttons (level)
//   hit, miss  one-cycle ball events from the graphics unit
//   gra_still  freeze graphics, ball parked at centre
//   state      game state for text overlay select
//   ball_cnt   balls remaining
//   score      two BCD digits {tens, ones}
//   timer_done pause timer at zero
// master: drives events/buttons and observes status; slave: the controller.
interface pong_game_ctrl_if;
  logic       refr_tick;
  logic [1:0] btn;
  logic       hit;
  logic       miss;
  logic       gra_still;
  logic [1:0] state;
  logic [1:0] ball_cnt;
  logic [7:0] score;
  logic       timer_done;

  modport master (
    output refr_tick, btn, hit, miss,
    input  gra_still, state, ball_cnt, score, timer_done
  );

  modport slave (
    input  refr_tick, btn, hit, miss,
    output gra_still, state, ball_cnt, score, timer_done
  );
endinterface

// File: rtl/pong_ctrl_timer.sv
// pong_ctrl_timer: frame-based pause timer.
//   clk, reset  clock and asynchronous active-low reset (count cleared)
//   tick        refresh tick; decrements the count while nonzero
//   start       loads TIMER_TICKS; wins over a coincident tick
//   done        count is zero
module pong_ctrl_timer #(
  parameter int TIMER_TICKS = 120
) (
  input  logic clk,
  input  logic reset,
  input  logic tick,
  input  logic start,
  output logic done
);

  localparam int CNT_W = $clog2(TIMER_TICKS + 1);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (start) begin
      count <= CNT_W'(TIMER_TICKS);
    end else if (tick && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign done = (count == '0);

endmodule

// File: rtl/pong_game_ctrl.sv
// pong_game_ctrl: game-level sequencer for the pong display.
//   clk    system clock (shared with VGA sync)
//   reset  asynchronous active-low reset
//   ctrl   pong_game_ctrl_if.slave: refr_tick/btn/hit/miss in,
//          gra_still/state/ball_cnt/score/timer_done out
// Build option: define PONG_CTRL_SCORE_EN to include the BCD score counter;
// without it score is tied to 0x00 and hit is ignored.
module pong_game_ctrl
  import pong_ctrl_pkg::*;
#(
  parameter int BALLS       = BALLS_DEF,
  parameter int TIMER_TICKS = TIMER_TICKS_DEF
) (
  input  logic             clk,
  input  logic             reset,
  pong_game_ctrl_if.slave  ctrl
);

  state_t     state_q;
  logic       gra_still_q;
  logic [1:0] ball_cnt_q;
  logic       pressed;
  logic       timer_start;
  logic       timer_done;

  assign pressed     = (ctrl.btn != 2'b00);
  // The pause starts on the same edge that leaves PLAY on a miss.
  assign timer_start = (state_q == PLAY) && ctrl.miss;

  pong_ctrl_timer #(
    .TIMER_TICKS (TIMER_TICKS)
  ) u_timer (
    .clk   (clk),
    .reset (reset),
    .tick  (ctrl.refr_tick),
    .start (timer_start),
    .done  (timer_done)
  );

  // gra_still is registered alongside the state so it never glitches.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= NEWGAME;
      gra_still_q <= 1'b1;
      ball_cnt_q  <= 2'(BALLS);
    end else begin
      case (state_q)
        NEWGAME: begin
          if (pressed) begin
            state_q     <= PLAY;
            gra_still_q <= 1'b0;
          end
        end
        PLAY: begin
          if (ctrl.miss) begin
            gra_still_q <= 1'b1;
            if (ball_cnt_q > 2'd1) begin
              ball_cnt_q <= ball_cnt_q - 2'd1;
              state_q    <= NEWBALL;
            end else begin
              ball_cnt_q <= 2'd0;
              state_q    <= OVER;
            end
          end
        end
        NEWBALL: begin
          // A press during the pause is not remembered.
          if (timer_done && pressed) begin
            state_q     <= PLAY;
            gra_still_q <= 1'b0;
          end
        end
        OVER: begin
          if (timer_done) begin
            state_q    <= NEWGAME;
            ball_cnt_q <= 2'(BALLS);
          end
        end
        default: begin
          state_q     <= NEWGAME;
          gra_still_q <= 1'b1;
        end
      endcase
    end
  end

`ifdef PONG_CTRL_SCORE_EN
  logic [7:0] score_q;

  // Saturating two-digit BCD increment.
  function automatic logic [7:0] bcd_inc(input logic [7:0] s);
    logic [BCD_W-1:0] tens;
    logic [BCD_W-1:0] ones;
    tens = s[7:4];
    ones = s[3:0];
    if (s == 8'h99) begin
      return s;
    end else if (ones == 4'd9) begin
      return {tens + 4'd1, 4'd0};
    end else begin
      return {tens, ones + 4'd1};
    end
  endfunction

  // Score is cleared only when a new game starts, so the final score stays
  // visible through OVER and NEWGAME.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      score_q <= 8'h00;
    end else if ((state_q == NEWGAME) && pressed) begin
      score_q <= 8'h00;
    end else if ((state_q == PLAY) && ctrl.hit) begin
      score_q <= bcd_inc(score_q);
    end
  end

  assign ctrl.score = score_q;
`else
  logic unused_hit;
  assign unused_hit = ctrl.hit;
  assign ctrl.score = 8'h00;
`endif

  assign ctrl.state      = state_q;
  assign ctrl.gra_still  = gra_still_q;
  assign ctrl.ball_cnt   = ball_cnt_q;
  assign ctrl.timer_done = timer_done;

endmodule
